// File: rtl/sm_adc_pkg.sv
// Shared constants, FSM state encodings and frame helper for the soil-moisture ADC front-end.
package sm_adc_pkg;

    localparam int FRAME_BITS     = 16;
    localparam int DATA_W         = 12;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int AVG_FRAMES     = 4;
    localparam int ACC_W          = 14;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARM   = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Control word bit k of the frame: ADD2..ADD0 sit at bits 2..4, everything else is zero.
    function automatic logic frame_bit(input logic [4:0] k, input logic [2:0] ch);
        logic b;
        b = 1'b0;
        if (k == 5'(ADDR_FIRST_BIT))
            b = ch[2];
        else if (k == 5'(ADDR_FIRST_BIT + 1))
            b = ch[1];
        else if (k == 5'(ADDR_FIRST_BIT + 2))
            b = ch[0];
        return b;
    endfunction

endpackage

// File: rtl/adc_clk_edge.sv
// Registers the divided ADC clock in the clk_50M domain and flags its rising/falling transitions.
module adc_clk_edge (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic adc_clk,
    output logic rise,
    output logic fall
);

    logic adc_clk_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            adc_clk_q <= 1'b1;
        else
            adc_clk_q <= adc_clk;
    end

    assign rise = adc_clk & ~adc_clk_q;
    assign fall = ~adc_clk & adc_clk_q;

endmodule

// File: rtl/adc_sample_controller.sv
// SPI-style frame controller for an 8-channel 12-bit ADC; one frame per start.
// Build option ADC_AVERAGE_EN: four frames per start, result is their mean.
module adc_sample_controller
    import sm_adc_pkg::*;
#(
    parameter logic [2:0] DEFAULT_CH = 3'd0
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              adc_clk,
    input  logic              start,
    input  logic              ch_sel_en,
    input  logic [2:0]        ch_sel,
    input  logic              adc_dout,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic              adc_din,
    output logic              busy,
    output logic              data_valid,
    output logic [DATA_W-1:0] data,
    output state_t            state_dbg
);

    // Handshake: start is a one-cycle request, taken only in IDLE while data_valid is low;
    // busy rises the next cycle and falls with the single-cycle data_valid pulse that presents data.

    logic              rise;
    logic              fall;
    state_t            state;
    logic [2:0]        ch_q;
    logic [4:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;

    adc_clk_edge u_edge (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .adc_clk (adc_clk),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef ADC_AVERAGE_EN
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [1:0]       frame_cnt;

    assign acc_sum = acc + ACC_W'(shreg);
`endif

    assign state_dbg = state;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ch_q       <= 3'd0;
            bit_cnt    <= 5'd0;
            shreg      <= '0;
            adc_cs_n   <= 1'b1;
            adc_sck    <= 1'b1;
            adc_din    <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
`ifdef ADC_AVERAGE_EN
            acc        <= '0;
            frame_cnt  <= 2'd0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !data_valid) begin
                        ch_q  <= ch_sel_en ? ch_sel : DEFAULT_CH;
                        busy  <= 1'b1;
                        state <= ST_ARM;
`ifdef ADC_AVERAGE_EN
                        acc       <= '0;
                        frame_cnt <= 2'd0;
`endif
                    end
                end

                ST_ARM, ST_GAP: begin
                    if (fall) begin
                        adc_cs_n <= 1'b0;
                        adc_sck  <= 1'b0;
                        bit_cnt  <= 5'd0;
                        adc_din  <= frame_bit(5'd0, ch_q);
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    adc_sck <= adc_clk;
                    if (fall)
                        adc_din <= frame_bit(bit_cnt, ch_q);
                    // Only the last 12 bits survive; the leading zeros shift out the top.
                    if (rise) begin
                        shreg   <= {shreg[DATA_W-2:0], adc_dout};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(FRAME_BITS - 1))
                            state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (fall) begin
                        adc_cs_n <= 1'b1;
                        adc_sck  <= 1'b1;
                        adc_din  <= 1'b0;
`ifdef ADC_AVERAGE_EN
                        if (frame_cnt == 2'(AVG_FRAMES - 1)) begin
                            data       <= acc_sum[ACC_W-1:2];
                            data_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            acc       <= acc_sum;
                            frame_cnt <= frame_cnt + 2'd1;
                            state     <= ST_GAP;
                        end
`else
                        data       <= shreg;
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_controller.sv
// Bench for adc_sample_controller: vector table, ADC serial model and data scoreboard.
module tb_adc_sample_controller;

    localparam logic [2:0] TB_DEFAULT_CH = 3'd2;
`ifdef ADC_AVERAGE_EN
    localparam int AVG_N   = 4;
    localparam int LAT_MIN = 1074;
    localparam int LAT_MAX = 1089;
`else
    localparam int AVG_N   = 1;
    localparam int LAT_MIN = 258;
    localparam int LAT_MAX = 273;
`endif

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        adc_clk = 1'b1;
    logic        start   = 1'b0;
    logic        ch_sel_en = 1'b0;
    logic [2:0]  ch_sel  = 3'd0;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        adc_din;
    logic        busy;
    logic        data_valid;
    logic [11:0] data;
    logic [2:0]  state_dbg;

    adc_sample_controller #(.DEFAULT_CH(TB_DEFAULT_CH)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .adc_clk    (adc_clk),
        .start      (start),
        .ch_sel_en  (ch_sel_en),
        .ch_sel     (ch_sel),
        .adc_dout   (adc_dout),
        .adc_cs_n   (adc_cs_n),
        .adc_sck    (adc_sck),
        .adc_din    (adc_din),
        .busy       (busy),
        .data_valid (data_valid),
        .data       (data),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset block ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ph    = 0;

    initial forever #10 clk_50M = ~clk_50M;

    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end

    // adc_clk: period 16 clk_50M cycles, high for 8
    initial forever begin
        @(posedge clk_50M);
        #1;
        ph      = (ph + 1) % 16;
        adc_clk = (ph < 8);
    end

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- ADC model, frame monitor, scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [11:0] samp_q[$];
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b1;
    logic [15:0] model_word = 16'd0;
    logic [15:0] din_bits = 16'd0;
    logic [15:0] last_din = 16'd0;
    int bit_idx = 0, rise_cnt = 0, last_rises = 0;
    int valid_cnt = 0, valid_cyc = 0, cs_rise_cyc = 0;
    int conv_frames = 0, min_gap = 1000;

    always @(negedge clk_50M) begin
        if (prev_cs && !adc_cs_n) begin
            if (conv_frames > 0 && (cyc - cs_rise_cyc) < min_gap)
                min_gap = cyc - cs_rise_cyc;
            conv_frames++;
            rise_cnt   = 0;
            din_bits   = 16'd0;
            model_word = (samp_q.size() > 0) ? {4'b0000, samp_q.pop_front()} : 16'd0;
            bit_idx    = 15;
            adc_dout   = model_word[15];
        end else if (!adc_cs_n && prev_sck && !adc_sck) begin
            if (bit_idx > 0)
                bit_idx--;
            adc_dout = model_word[bit_idx];
        end
        if (!adc_cs_n && !prev_sck && adc_sck) begin
            if (rise_cnt < 16)
                din_bits[rise_cnt] = adc_din;
            rise_cnt++;
        end
        if (!prev_cs && adc_cs_n) begin
            last_rises  = rise_cnt;
            last_din    = din_bits;
            cs_rise_cyc = cyc;
            adc_dout    = 1'b0;
        end
        if (data_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (exp_q.size() == 0)
                check("unexpected_valid", 32'(data_valid), 32'd0);
            else
                check("data", 32'(data), 32'(exp_q.pop_front()));
        end
        prev_cs  = adc_cs_n;
        prev_sck = adc_sck;
    end

    // ---------------- driver tasks ----------------
    task automatic push_samples(input logic [11:0] smp);
        for (int i = 0; i < AVG_N; i++)
            samp_q.push_back(smp);
    endtask

    task automatic run_conv(input logic en, input logic [2:0] ch, input logic [2:0] exp_addr,
                            input logic [11:0] exp_data, input int extra_at, output int lat);
        int v0, c0, n;
        exp_q.push_back(exp_data);
        conv_frames = 0;
        min_gap     = 1000;
        v0          = valid_cnt;
        c0          = cyc;
        start       = 1'b1;
        ch_sel_en   = en;
        ch_sel      = ch;
        @(posedge clk_50M); #2;
        start     = 1'b0;
        ch_sel_en = ~en;
        ch_sel    = ~ch;
        check("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (valid_cnt == v0 && n < 2000) begin
            start = (extra_at > 0 && n == extra_at);
            @(posedge clk_50M); #2;
            n++;
        end
        start = 1'b0;
        check("valid_count", 32'(valid_cnt - v0), 32'd1);
        lat = valid_cyc - c0;
        check_range("latency", lat, LAT_MIN, LAT_MAX);
        check("busy_after_valid", 32'(busy), 32'd0);
        check("sck_rises", 32'(last_rises), 32'd16);
        check("frames", 32'(conv_frames), 32'(AVG_N));
        check("din_addr", 32'({last_din[2], last_din[3], last_din[4]}), 32'(exp_addr));
        check("din_zero_bits", 32'(last_din & 16'hFFE3), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic        en;
        logic [2:0]  ch;
        logic [11:0] smp;
        logic [2:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, v0, n, lat_min, lat_max;
        logic [2:0]  rch;
        logic [11:0] rsmp;

        vecs[0] = '{en: 1'b1, ch: 3'd5, smp: 12'hA5C, exp_addr: 3'd5};
        vecs[1] = '{en: 1'b0, ch: 3'd7, smp: 12'h123, exp_addr: TB_DEFAULT_CH};
        vecs[2] = '{en: 1'b1, ch: 3'd0, smp: 12'hFFF, exp_addr: 3'd0};
        vecs[3] = '{en: 1'b1, ch: 3'd7, smp: 12'h000, exp_addr: 3'd7};
        vecs[4] = '{en: 1'b1, ch: 3'd6, smp: 12'h801, exp_addr: 3'd6};

        repeat (5) @(posedge clk_50M);
        #2 rst_n = 1'b1;
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sck", 32'(adc_sck), 32'd1);
        check("rst_din", 32'(adc_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        repeat (100) @(posedge clk_50M);
        #2;
        check("idle_cs_n", 32'(adc_cs_n), 32'd1);
        check("idle_sck", 32'(adc_sck), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", 32'(data), 32'd0);
        check("idle_no_valid", 32'(valid_cnt), 32'd0);

        // vector table
        for (int i = 0; i < 5; i++) begin
            push_samples(vecs[i].smp);
            run_conv(vecs[i].en, vecs[i].ch, vecs[i].exp_addr, vecs[i].smp, 0, lat);
            repeat ($urandom_range(1, 20)) @(posedge clk_50M);
            #2;
        end
        repeat (30) @(posedge clk_50M);
        #2 check("data_held", 32'(data), 32'(vecs[4].smp));

        // start during busy is dropped, channel stays latched
        push_samples(12'h3C3);
        v0 = valid_cnt;
        run_conv(1'b0, 3'd6, TB_DEFAULT_CH, 12'h3C3, 60, lat);
        repeat (300) @(posedge clk_50M);
        #2;
        check("busy_drop_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("busy_drop_idle", 32'(busy), 32'd0);

        // start coincident with data_valid is dropped
        push_samples(12'h5A5);
        exp_q.push_back(12'h5A5);
        v0 = valid_cnt;
        start = 1'b1; ch_sel_en = 1'b1; ch_sel = 3'd3;
        @(posedge clk_50M); #2 start = 1'b0;
        n = 0;
        while (!data_valid && n < 2000) begin
            @(posedge clk_50M); #2;
            n++;
        end
        start = 1'b1;
        @(posedge clk_50M); #2 start = 1'b0;
        check("coincident_busy", 32'(busy), 32'd0);
        repeat (350) @(posedge clk_50M);
        #2;
        check("coincident_one_valid", 32'(valid_cnt - v0), 32'd1);

        // reset in the middle of a frame
        push_samples(12'h777);
        exp_q.push_back(12'h777);
        start = 1'b1; ch_sel_en = 1'b1; ch_sel = 3'd1;
        @(posedge clk_50M); #2 start = 1'b0;
        n = 0;
        while (!(rise_cnt == 8 && !adc_cs_n) && n < 600) begin
            @(posedge clk_50M); #2;
            n++;
        end
        check("reached_bit8", 32'(rise_cnt), 32'd8);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
        check("midrst_sck", 32'(adc_sck), 32'd1);
        check("midrst_din", 32'(adc_din), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        exp_q.delete();
        samp_q.delete();
        v0 = valid_cnt;
        repeat (5) @(posedge clk_50M);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk_50M);
        #2 check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        push_samples(12'h9E1);
        run_conv(1'b1, 3'd4, 3'd4, 12'h9E1, 0, lat);

        // start at each adc_clk phase
        lat_min = 100000;
        lat_max = 0;
        for (int p = 0; p < 16; p++) begin
            n = 0;
            while (ph != p && n < 40) begin
                @(posedge clk_50M); #2;
                n++;
            end
            rch  = 3'($urandom_range(0, 7));
            rsmp = 12'($urandom_range(0, 4095));
            push_samples(rsmp);
            run_conv(1'b1, rch, rch, rsmp, 0, lat);
            if (lat < lat_min) lat_min = lat;
            if (lat > lat_max) lat_max = lat;
        end
        check("phase_lat_min", 32'(lat_min), 32'(LAT_MIN));
        check("phase_lat_max", 32'(lat_max), 32'(LAT_MAX));

`ifdef ADC_AVERAGE_EN
        samp_q.push_back(12'h100);
        samp_q.push_back(12'h104);
        samp_q.push_back(12'h108);
        samp_q.push_back(12'h10C);
        v0 = valid_cnt;
        run_conv(1'b1, 3'd5, 3'd5, 12'h106, 0, lat);
        total++;
        if (min_gap < 16) begin
            bad++;
            $display("FAIL avg_gap: got %0d expected >=16", min_gap);
        end
        repeat (50) @(posedge clk_50M);
        #2 check("avg_one_valid", 32'(valid_cnt - v0), 32'd1);
`endif

        repeat (20) @(posedge clk_50M);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
